// File: rtl/pipe_skid_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_skid_reg : two-entry skid register with registered-only outputs.     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module pipe_skid_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;

   logic in_xfer;
   logic out_xfer;

   // Handshake qualifiers only steer the next state; no input reaches an output.
   assign in_xfer  = in_valid  && (state != FULL);
   assign out_xfer = out_ready && (state != EMPTY);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_xfer) begin
                  main_q <= in_data;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (in_xfer && out_xfer) begin
                  main_q <= in_data;
               end else if (in_xfer) begin
                  skid_q <= in_data;
                  state  <= FULL;
               end else if (out_xfer) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (out_xfer) begin
                  main_q <= skid_q;
                  state  <= BUSY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign out_data  = main_q;
   assign count     = state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// Randomized and directed bench for pipe_skid_reg against a queue reference model.
module tb_pipe_skid_reg;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_l = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready = 1'b0;
   logic [1:0]       count;

   int checks = 0;
   int errors = 0;
   logic [WIDTH-1:0] q[$];

   pipe_skid_reg #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_l     (rst_l),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Compare all outputs against the queue contents.
   task automatic check_model(input string tag);
      check_eq({tag, ".count"}, WIDTH'(count), WIDTH'(q.size()));
      check_eq({tag, ".out_valid"}, WIDTH'(out_valid), WIDTH'(q.size() > 0));
      check_eq({tag, ".in_ready"}, WIDTH'(in_ready), WIDTH'(q.size() < 2));
      if (q.size() > 0) check_eq({tag, ".out_data"}, out_data, q[0]);
   endtask

   // Drive one cycle from a negedge, update the model at the posedge, check at the next negedge.
   task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f, input string tag);
      int sz;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      @(posedge clk);
      sz = q.size();
      if (r && sz > 0) void'(q.pop_front());
      if (f) q.delete();
      else if (v && sz < 2) q.push_back(d);
      @(negedge clk);
      check_model(tag);
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      check_eq("rst.out_valid", WIDTH'(out_valid), '0);
      check_eq("rst.in_ready", WIDTH'(in_ready), WIDTH'(1));
      check_eq("rst.count", WIDTH'(count), '0);
      check_eq("rst.out_data", out_data, '0);
      rst_l = 1'b1;

      // Single word, one-cycle latency, first edge after reset accepts
      cycle(1'b1, 32'hA5, 1'b1, 1'b0, "single.push");
      check_eq("single.data", out_data, 32'hA5);
      check_eq("single.valid", WIDTH'(out_valid), WIDTH'(1));
      cycle(1'b0, 32'h0, 1'b1, 1'b0, "single.drain");
      check_eq("single.empty", WIDTH'(count), '0);

      // Backpressure fills the skid, third word waits
      cycle(1'b1, 32'h11, 1'b0, 1'b0, "bp.p1");
      cycle(1'b1, 32'h22, 1'b0, 1'b0, "bp.p2");
      check_eq("bp.count2", WIDTH'(count), WIDTH'(2));
      check_eq("bp.in_ready0", WIDTH'(in_ready), '0);
      check_eq("bp.head", out_data, 32'h11);
      cycle(1'b1, 32'h33, 1'b0, 1'b0, "bp.p3_blocked");
      check_eq("bp.hold", out_data, 32'h11);
      cycle(1'b1, 32'h33, 1'b1, 1'b0, "bp.pop1");
      check_eq("bp.second", out_data, 32'h22);
      cycle(1'b1, 32'h33, 1'b1, 1'b0, "bp.pop2_push3");
      check_eq("bp.third", out_data, 32'h33);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, "bp.drain");

      // Continuous stream without bubbles
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, WIDTH'(i), 1'b1, 1'b0, "stream");
         check_eq("stream.data", out_data, WIDTH'(i));
         check_eq("stream.valid", WIDTH'(out_valid), WIDTH'(1));
         check_eq("stream.count", WIDTH'(count), WIDTH'(1));
      end
      cycle(1'b0, 32'h0, 1'b1, 1'b0, "stream.drain");

      // Flush from FULL discards the offered word
      cycle(1'b1, 32'h44, 1'b0, 1'b0, "fl.p1");
      cycle(1'b1, 32'h55, 1'b0, 1'b0, "fl.p2");
      cycle(1'b1, 32'h66, 1'b0, 1'b1, "fl.flush");
      check_eq("fl.count", WIDTH'(count), '0);
      check_eq("fl.out_valid", WIDTH'(out_valid), '0);
      check_eq("fl.in_ready", WIDTH'(in_ready), WIDTH'(1));
      cycle(1'b0, 32'h0, 1'b1, 1'b0, "fl.idle");

      // Asynchronous reset mid-operation
      cycle(1'b1, 32'h77, 1'b0, 1'b0, "ar.push");
      #2 rst_l = 1'b0;
      #1;
      check_eq("ar.out_valid", WIDTH'(out_valid), '0);
      check_eq("ar.out_data", out_data, '0);
      check_eq("ar.count", WIDTH'(count), '0);
      check_eq("ar.in_ready", WIDTH'(in_ready), WIDTH'(1));
      q.delete();
      #1 rst_l = 1'b1;
      cycle(1'b1, 32'h88, 1'b0, 1'b0, "ar.first");
      check_eq("ar.first_data", out_data, 32'h88);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, "ar.drain");

      // Randomized traffic against the reference queue
      for (int n = 0; n < 10000; n++) begin
         cycle(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 63) == 0), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits, SHALL be legal for any value >= 1.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst_l  input  1  asynchronous active-low reset; SHALL clear state on negedge rst_l, independent of clk.
REQ-004 flush  input  1  synchronous pipeline flush, active-high.
REQ-005 in_valid  input  1  upstream writer presents in_data.
REQ-006 in_data  input  WIDTH  upstream payload.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 out_valid  output  1  out_data holds a valid word.
REQ-009 out_data  output  WIDTH  downstream payload.
REQ-010 out_ready  input  1  downstream reader accepts out_data this cycle.
REQ-011 count  output  2  words held (0, 1 or 2).

Function
REQ-012 Storage SHALL be two WIDTH-bit registers: main (drives out_data) and skid (overflow).
REQ-013 State machine SHALL have exactly three states: EMPTY (count=0), BUSY (main valid, count=1), FULL (main and skid valid, count=2).
REQ-014 Outputs SHALL depend only on state and registers, with no combinational path from any input: in_ready = (state != FULL); out_valid = (state != EMPTY); out_data = main; count encodes state.
REQ-015 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-016 EMPTY: input transfer -> main <= in_data, go to BUSY; otherwise stay EMPTY.
REQ-017 BUSY, simultaneous input and output transfers -> main <= in_data, stay BUSY.
REQ-018 BUSY, input transfer only -> skid <= in_data, main unchanged, go to FULL.
REQ-019 BUSY, output transfer only -> go to EMPTY.
REQ-020 BUSY, no transfer -> hold.
REQ-021 FULL: output transfer -> main <= skid, go to BUSY; otherwise hold. in_valid SHALL be ignored.
REQ-022 Latency: a word accepted at edge N SHALL appear on out_data with out_valid=1 after edge N (1 cycle); zero-bubble throughput of 1 word/cycle when out_ready is held high.
REQ-023 Ordering SHALL be strict FIFO; no word SHALL be dropped or duplicated unless flushed.
REQ-024 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 flush=1 SHALL take priority over all transfers: next state EMPTY, any input offered that cycle discarded, data registers may retain stale contents.
REQ-026 An output transfer coinciding with flush SHALL still count as consumed by downstream; no replay.

Reset
REQ-027 While rst_l=0: state=EMPTY, main=0, skid=0; hence out_valid=0, in_ready=1, count=0, out_data=0.
REQ-028 Reset asserted mid-operation SHALL discard both held words immediately, without waiting for clk.
REQ-029 First transfer after reset release SHALL be accepted on the first posedge with rst_l=1.

Verification
REQ-030 Reset, then in_valid=1 with data 0xA5 for one cycle, out_ready=1 -> next cycle out_valid=1, out_data=0xA5; following cycle out_valid=0, count=0.
REQ-031 out_ready=0, push 0x11 then 0x22 -> count=2, in_ready=0, out_data=0x11; a third push 0x33 offered is not accepted; raise out_ready -> 0x11, 0x22 delivered in order, then 0x33 accepted once in_ready=1.
REQ-032 Continuous stream 1..16 with in_valid=out_ready=1 -> 16 consecutive outputs 1..16, no bubbles, count never exceeds 1.
REQ-033 In FULL with words 0x44, 0x55, assert flush with in_valid=1 data 0x66 -> next cycle count=0, out_valid=0, in_ready=1; 0x66 never appears.
REQ-034 In BUSY with 0x77 and out_ready=0, drop rst_l between clock edges -> out_valid=0, out_data=0, count=0 immediately, before the next edge.
REQ-035 Random in_valid/out_ready (>=10k cycles) against a reference queue -> in-order, lossless delivery; count always matches the queue depth.
